aud_i2s_tx: RTL and testbench

AUD_I2S_TX -- requirements
Module: aud_i2s_tx

---
 rtl/aud_i2s_tx_pkg.sv | 13 +
 rtl/aud_clk_sync.sv | 35 +++
 rtl/aud_i2s_tx.sv | 116 +++++++++++
 tb/tb_aud_i2s_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_i2s_tx_pkg.sv
// Shared defaults and tx state encoding for the I2S transmit path.
package aud_i2s_tx_pkg;

    localparam int AUD_DATA_W = 16;
    localparam int AUD_SLOT_W = 32;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LEFT  = 2'd1,
        TX_RIGHT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/aud_clk_sync.sv
// Brings the externally generated bit clock and word select into the clk domain
// and flags each bit-clock falling edge.
module aud_clk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic aud_bclk,
    input  logic aud_lrc,
    output logic bclk_fall,
    output logic lrc_value
);

    logic bclk_p0, bclk_p1, bclk_p2;
    logic lrc_p0, lrc_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_p0 <= 1'b0;
            bclk_p1 <= 1'b0;
            bclk_p2 <= 1'b0;
            lrc_p0  <= 1'b0;
            lrc_p1  <= 1'b0;
        end else begin
            bclk_p0 <= aud_bclk;
            bclk_p1 <= bclk_p0;
            bclk_p2 <= bclk_p1;
            lrc_p0  <= aud_lrc;
            lrc_p1  <= lrc_p0;
        end
    end

    // bclk_p2 only holds history for edge detection; lrc_p1 aligns with bclk_p1.
    assign bclk_fall = bclk_p2 & ~bclk_p1;
    assign lrc_value = lrc_p1;

endmodule

// File: rtl/aud_i2s_tx.sv
// I2S transmitter: one-deep holding buffer feeding a left/right slot serializer
// that advances on falling edges of the synchronized bit clock.
module aud_i2s_tx
    import aud_i2s_tx_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int SLOT_W = AUD_SLOT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     aud_bclk,
    input  logic                     aud_lrc,
    input  logic signed [DATA_W-1:0] audio_left_i,
    input  logic signed [DATA_W-1:0] audio_right_i,
    input  logic                     audio_valid,
    output logic                     audio_ready,
    output logic                     aud_dacdat,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Indices at or beyond DATA_W shift the sample out entirely, giving the zero pad.
    function automatic logic slot_bit(input logic [DATA_W-1:0] word,
                                      input logic [CNT_W-1:0]  idx);
        logic [DATA_W-1:0] sh;
        sh = word << idx;
        return sh[DATA_W-1];
    endfunction

    logic bclk_fall, lrc_value;
    logic lrc_prev, lrc_fell, lrc_rose, left_entry;

    tx_state_e               state;
    logic [CNT_W-1:0]        bit_cnt;
    logic signed [DATA_W-1:0] tx_left, tx_right;
    logic signed [DATA_W-1:0] hold_left, hold_right;

    aud_clk_sync u_clk_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .aud_bclk  (aud_bclk),
        .aud_lrc   (aud_lrc),
        .bclk_fall (bclk_fall),
        .lrc_value (lrc_value)
    );

    assign lrc_fell   = bclk_fall & lrc_prev & ~lrc_value;
    assign lrc_rose   = bclk_fall & ~lrc_prev & lrc_value;
    assign left_entry = lrc_fell & (state != TX_LEFT);

    // The transition edge still emits the outgoing slot's bit; the new MSB follows
    // one bit clock later, which gives the standard I2S one-bit delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            lrc_prev   <= 1'b0;
            bit_cnt    <= '0;
            aud_dacdat <= 1'b0;
        end else if (bclk_fall) begin
            lrc_prev <= lrc_value;
            case (state)
                TX_LEFT:  aud_dacdat <= slot_bit(tx_left, bit_cnt);
                TX_RIGHT: aud_dacdat <= slot_bit(tx_right, bit_cnt);
                default:  aud_dacdat <= 1'b0;
            endcase
            if (left_entry) begin
                state   <= TX_LEFT;
                bit_cnt <= '0;
            end else if (lrc_rose && state == TX_LEFT) begin
                state   <= TX_RIGHT;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= sat_inc(bit_cnt);
            end
        end
    end

    // Holding buffer; on an empty LEFT entry the tx pair is left as is and replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_left   <= '0;
            hold_right  <= '0;
            tx_left     <= '0;
            tx_right    <= '0;
            audio_ready <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (left_entry && !audio_ready) begin
                tx_left     <= hold_left;
                tx_right    <= hold_right;
                audio_ready <= 1'b1;
                frame_start <= 1'b1;
            end else begin
                if (left_entry) begin
                    underrun <= 1'b1;
                end
                if (audio_valid && audio_ready) begin
                    hold_left   <= audio_left_i;
                    hold_right  <= audio_right_i;
                    audio_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: generates bclk/lrc, offers sample pairs and compares the
// serial stream and handshake against a slot-level reference model.
module tb_aud_i2s_tx;

    localparam int DATA_W  = 16;
    localparam int SLOT_W  = 32;
    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic aud_bclk = 1'b0;
    logic aud_lrc = 1'b1;
    logic audio_valid = 1'b0;
    logic signed [DATA_W-1:0] audio_left_i = '0;
    logic signed [DATA_W-1:0] audio_right_i = '0;
    logic audio_ready, aud_dacdat, frame_start, underrun;

    int checks = 0;
    int errors = 0;
    int obs_fs = 0, obs_ur = 0, exp_fs = 0, exp_ur = 0;

    int div = 0, since_fall = 0, edge_no = 0, slot_len = SLOT_W;
    bit short_left = 0, rnd_mode = 0, ready_chk = 0;

    int mst = M_IDLE, pos = 0, le_cnt = 0;
    bit lp = 0, pend_full = 0, exp_bit = 0, copied_now = 0;
    logic [DATA_W-1:0] pend_l = '0, pend_r = '0, tx_l = '0, tx_r = '0, cur_word = '0;
    logic [DATA_W-1:0] left_cap = '0, right_cap = '0;

    aud_i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .aud_bclk      (aud_bclk),
        .aud_lrc       (aud_lrc),
        .audio_left_i  (audio_left_i),
        .audio_right_i (audio_right_i),
        .audio_valid   (audio_valid),
        .audio_ready   (audio_ready),
        .aud_dacdat    (aud_dacdat),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start === 1'b1) obs_fs++;
        if (underrun === 1'b1) obs_ur++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit slot_bit(input logic [DATA_W-1:0] w, input int idx);
        bit b;
        b = 1'b0;
        if (idx < DATA_W) b = w[DATA_W-1-idx];
        return b;
    endfunction

    // Slot-level model: each slot is the sample MSB-first then zeros, delayed one bit.
    task automatic model_fall();
        bit fell, rose;
        copied_now = 0;
        if (!rst_n) begin
            exp_bit = 0;
        end else begin
            fell = lp && !aud_lrc;
            rose = !lp && aud_lrc;
            lp = aud_lrc;
            exp_bit = (mst == M_IDLE) ? 1'b0 : slot_bit(cur_word, pos);
            if (fell && mst != M_LEFT) begin
                if (pend_full) begin
                    tx_l = pend_l; tx_r = pend_r; pend_full = 0; copied_now = 1; exp_fs++;
                end else begin
                    exp_ur++;
                end
                mst = M_LEFT; cur_word = tx_l; pos = 0; le_cnt++;
            end else if (rose && mst == M_LEFT) begin
                mst = M_RIGHT; cur_word = tx_r; pos = 0;
            end else if (pos < SLOT_W - 1) begin
                pos++;
            end
        end
    endtask

    task automatic model_reset();
        mst = M_IDLE; pos = 0; pend_full = 0; tx_l = '0; tx_r = '0;
        cur_word = '0; lp = 0; exp_bit = 0; copied_now = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        audio_valid = 1'b0;
        if (ready_chk) begin
            check_eq("ready_after_valid", audio_ready, !pend_full);
            ready_chk = 0;
        end
        since_fall++;
        div++;
        if (div == 8) begin
            div = 0;
            if (aud_bclk) begin
                aud_bclk = 1'b0;
                since_fall = 0;
                edge_no++;
                if (edge_no >= slot_len) begin
                    aud_lrc = ~aud_lrc;
                    edge_no = 0;
                    slot_len = SLOT_W;
                    if (!aud_lrc && short_left) begin
                        slot_len = 11; short_left = 0;
                    end else if (rnd_mode && $urandom_range(0, 5) == 0) begin
                        slot_len = $urandom_range(2, SLOT_W - 1);
                    end
                end
                model_fall();
            end else begin
                aud_bclk = 1'b1;
            end
        end
        if (since_fall == 6) begin
            check_eq("dacdat", aud_dacdat, exp_bit);
            check_eq("ready", audio_ready, !pend_full);
            if (mst == M_LEFT && pos >= 1 && pos <= DATA_W)
                left_cap = {left_cap[DATA_W-2:0], aud_dacdat};
            if (mst == M_RIGHT && pos >= 1 && pos <= DATA_W)
                right_cap = {right_cap[DATA_W-2:0], aud_dacdat};
        end
    endtask

    task automatic offer(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        audio_left_i = l; audio_right_i = r; audio_valid = 1'b1;
        if (!pend_full && !(since_fall == 2 && copied_now)) begin
            pend_l = l; pend_r = r; pend_full = 1;
        end
        ready_chk = 1;
    endtask

    task automatic offer_at(input int sf, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int n = 0;
        while (since_fall != sf && n < 64) begin tick(); n++; end
        offer(l, r);
    endtask

    task automatic wait_entry();
        int start = le_cnt;
        int n = 0;
        while (le_cnt == start && n < 5000) begin tick(); n++; end
        if (le_cnt == start) check_eq("entry_timeout", 0, 1);
    endtask

    task automatic settle();
        do tick(); while (since_fall != 7);
    endtask

    task automatic release_reset();
        int n = 0;
        while (!(aud_bclk && since_fall == 10) && n < 64) begin tick(); n++; end
        rst_n = 1'b1;
    endtask

    task automatic check_pair(input string tag, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        check_eq({tag, "_left"}, left_cap, l);
        check_eq({tag, "_right"}, right_cap, r);
        check_eq({tag, "_fs_cnt"}, obs_fs, exp_fs);
        check_eq({tag, "_ur_cnt"}, obs_ur, exp_ur);
    endtask

    initial begin
        int u0, n;
        logic [DATA_W-1:0] trunc_word;

        repeat (4) tick();
        check_eq("rst_dacdat", aud_dacdat, 0);
        check_eq("rst_ready", audio_ready, 1);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_underrun", underrun, 0);
        release_reset();

        offer_at(12, 16'h8001, 16'h7FFE);
        wait_entry(); settle();
        check_eq("first_fs_once", obs_fs, 1);
        check_eq("first_no_ur", obs_ur, 0);
        wait_entry(); settle();
        check_pair("p8001", 16'h8001, 16'h7FFE);

        offer_at(8, 16'h1234, 16'h5678);
        wait_entry(); settle();
        u0 = obs_ur;
        wait_entry(); settle();
        check_pair("rep1", 16'h1234, 16'h5678);
        wait_entry(); settle();
        check_pair("rep2", 16'h1234, 16'h5678);
        check_eq("ur_twice", obs_ur - u0, 2);

        offer_at(8, 16'hAAAA, 16'hAAAA);
        repeat (20) tick();
        offer_at(8, 16'h5555, 16'h5555);
        tick();
        check_eq("ready_held_full", audio_ready, 0);
        wait_entry(); settle();
        check_pair("rep3", 16'h1234, 16'h5678);
        check_eq("ur_still_twice", obs_ur - u0, 2);
        wait_entry(); settle();
        check_pair("paaaa", 16'hAAAA, 16'hAAAA);

        wait_entry();
        tick(); tick();
        offer(16'hBEEF, 16'hCAFE);
        settle();
        check_eq("coinc_ready_low", audio_ready, 0);
        check_eq("coinc_ur", obs_ur, exp_ur);
        wait_entry(); settle();
        check_pair("coinc_replay", 16'hAAAA, 16'hAAAA);
        wait_entry(); settle();
        check_pair("pbeef", 16'hBEEF, 16'hCAFE);

        offer_at(8, 16'h0F0F, 16'hFFFF);
        wait_entry();
        n = 0;
        while (!(mst == M_RIGHT && pos == 10 && since_fall == 7) && n < 3000) begin tick(); n++; end
        check_eq("pre_rst_dacdat", aud_dacdat, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_dacdat", aud_dacdat, 0);
        check_eq("mid_rst_ready", audio_ready, 1);
        check_eq("mid_rst_fs", frame_start, 0);
        model_reset();
        repeat (40) tick();
        release_reset();
        offer_at(12, 16'hC3C3, 16'h3C3C);
        wait_entry(); settle();
        wait_entry(); settle();
        check_pair("post_rst", 16'hC3C3, 16'h3C3C);

        short_left = 1;
        offer_at(8, 16'h1357, 16'h2468);
        wait_entry(); settle();
        wait_entry(); settle();
        trunc_word = 16'h1357;
        check_eq("trunc_left", left_cap[9:0], trunc_word[15:6]);
        check_eq("trunc_right", right_cap, 16'h2468);
        check_eq("trunc_fs_cnt", obs_fs, exp_fs);

        rnd_mode = 1;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (since_fall >= 2 && $urandom_range(0, 511) == 0)
                offer(16'($urandom), 16'($urandom));
        end
        settle();
        check_eq("rnd_fs_cnt", obs_fs, exp_fs);
        check_eq("rnd_ur_cnt", obs_ur, exp_ur);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
